// File: rtl/code_ram_arbiter.sv
// code_ram_arbiter: shares one single-port synchronous code RAM between the
// CPU instruction-fetch port (read-only) and the CPU data port (read/write).
// Both CPU ports are pipelined Avalon-MM slaves (waitrequest/readdatavalid).
// Contention is resolved round-robin. Out-of-range accesses are flagged and
// never reach the RAM. A read returns exactly one cycle after acceptance.
module code_ram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4,
  parameter int DEPTH  = 40000,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  // instruction-fetch slave
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic              i_waitrequest,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_readdatavalid,
  // data slave
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [BE_W-1:0]   d_byteenable,
  input  logic [DATA_W-1:0] d_writedata,
  output logic              d_waitrequest,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_readdatavalid,
  // RAM master
  output logic [ADDR_W-1:0] ram_address,
  output logic [BE_W-1:0]   ram_byteenable,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  input  logic [DATA_W-1:0] ram_readdata,
  // status
  output logic              oob_error,
  output logic [CNT_W-1:0]  conflict_count
);

  // Address is inside the populated part of the RAM.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(DEPTH));
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Round-robin pointer: 0 = fetch wins the next contended cycle, 1 = data.
  logic             ptr_q, ptr_d;
  // Read-return tag: a read was accepted last cycle, which port, out of range.
  logic             tag_vld_q, tag_vld_d;
  logic             tag_port_q, tag_port_d;
  logic             tag_oob_q, tag_oob_d;
  logic             oob_err_q, oob_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             i_req, d_req, contend;
  logic             gnt_i, gnt_d, accept;
  logic [ADDR_W-1:0] sel_addr;
  logic             sel_in_range;
  logic             rd_ok;
  logic [DATA_W-1:0] ret_data;

  // Request decode and grant; reset holds both ports off.
  always_comb begin
    i_req   = i_read;
    d_req   = d_read | d_write;
    contend = i_req & d_req;
    gnt_i   = 1'b0;
    gnt_d   = 1'b0;
    if (!reset) begin
      if (contend) begin
        gnt_i = ~ptr_q;
        gnt_d = ptr_q;
      end else begin
        gnt_i = i_req;
        gnt_d = d_req;
      end
    end
    accept        = gnt_i | gnt_d;
    i_waitrequest = ~gnt_i;
    d_waitrequest = ~gnt_d;
  end

  // Steer the winner onto the RAM; out-of-range accesses are not selected.
  always_comb begin
    sel_addr       = gnt_d ? d_address : i_address;
    sel_in_range   = in_range(sel_addr);
    ram_address    = sel_addr;
    ram_byteenable = gnt_d ? d_byteenable : {BE_W{1'b1}};
    ram_writedata  = gnt_d ? d_writedata : {DATA_W{1'b0}};
    ram_chipselect = accept & sel_in_range;
    ram_write      = gnt_d & d_write & sel_in_range;
    ram_clken      = 1'b1;
  end

  // Next-state for pointer, return tag, error pulse and contention counter.
  always_comb begin
    ptr_d      = contend ? ~ptr_q : ptr_q;
    tag_vld_d  = gnt_i | (gnt_d & ~d_write);
    tag_port_d = gnt_d;
    tag_oob_d  = ~sel_in_range;
    oob_err_d  = accept & ~sel_in_range;
    cnt_d      = contend ? sat_inc(cnt_q) : cnt_q;
  end

  // Control state; everything clears on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= 1'b0;
      tag_vld_q  <= 1'b0;
      tag_port_q <= 1'b0;
      tag_oob_q  <= 1'b0;
      oob_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ptr_q      <= ptr_d;
      tag_vld_q  <= tag_vld_d;
      tag_port_q <= tag_port_d;
      tag_oob_q  <= tag_oob_d;
      oob_err_q  <= oob_err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Read return: RAM q passes straight through to the tagged port; an
  // out-of-range read returns zero. A pending return is suppressed while
  // reset is asserted so nothing leaks out across a reset.
  always_comb begin
    rd_ok           = tag_vld_q & ~reset;
    i_readdatavalid = rd_ok & ~tag_port_q;
    d_readdatavalid = rd_ok & tag_port_q;
    ret_data        = tag_oob_q ? {DATA_W{1'b0}} : ram_readdata;
    i_readdata      = i_readdatavalid ? ret_data : {DATA_W{1'b0}};
    d_readdata      = d_readdatavalid ? ret_data : {DATA_W{1'b0}};
    oob_error       = oob_err_q;
    conflict_count  = cnt_q;
  end

endmodule

// File: tb/tb_code_ram_arbiter.sv
// tb_code_ram_arbiter: drives both CPU ports against a behavioural code RAM,
// predicts grants/RAM strobes with a small reference model and checks read
// returns through per-port scoreboard queues.
module tb_code_ram_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int DEPTH  = 40000;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] i_address;
  logic              i_read;
  logic              i_waitrequest;
  logic [DATA_W-1:0] i_readdata;
  logic              i_readdatavalid;
  logic [ADDR_W-1:0] d_address;
  logic              d_read;
  logic              d_write;
  logic [BE_W-1:0]   d_byteenable;
  logic [DATA_W-1:0] d_writedata;
  logic              d_waitrequest;
  logic [DATA_W-1:0] d_readdata;
  logic              d_readdatavalid;
  logic [ADDR_W-1:0] ram_address;
  logic [BE_W-1:0]   ram_byteenable;
  logic              ram_chipselect;
  logic              ram_write;
  logic [DATA_W-1:0] ram_writedata;
  logic              ram_clken;
  logic [DATA_W-1:0] ram_readdata;
  logic              oob_error;
  logic [CNT_W-1:0]  conflict_count;

  code_ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest),
    .i_readdata(i_readdata), .i_readdatavalid(i_readdatavalid),
    .d_address(d_address), .d_read(d_read), .d_write(d_write),
    .d_byteenable(d_byteenable), .d_writedata(d_writedata),
    .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .d_readdatavalid(d_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata),
    .oob_error(oob_error), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, 1-cycle synchronous read.
  logic [DATA_W-1:0] ram_mem [65536];
  always @(posedge clk) begin
    if (ram_chipselect && ram_clken) begin
      if (ram_write) begin
        for (int b = 0; b < BE_W; b++)
          if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end
      ram_readdata <= ram_mem[ram_address];
    end
  end

  // Reference model state.
  logic [DATA_W-1:0] shadow [65536];
  logic [DATA_W-1:0] qi[$];
  logic [DATA_W-1:0] qd[$];
  bit                ptr_m;
  int                cnt_m;
  bit                pend_i, pend_d, exp_oob;
  int                n_tests = 0;
  int                n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                              input logic [DATA_W-1:0] wd,
                                              input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] r;
    r = old;
    for (int b = 0; b < BE_W; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // One clock cycle: drive, check against the model, advance the model.
  task automatic cycle(input bit rst, input bit ir, input logic [15:0] ia,
                       input bit dr, input bit dw, input logic [15:0] da,
                       input logic [3:0] be, input logic [31:0] wd);
    bit gi, gd, cont, inr, acc, popped;
    logic [15:0] sa;
    logic [31:0] e;
    @(negedge clk);
    reset = rst; i_read = ir; i_address = ia;
    d_read = dr; d_write = dw; d_address = da; d_byteenable = be; d_writedata = wd;
    #1;
    cont = ir & (dr | dw);
    gi = 1'b0; gd = 1'b0;
    if (!rst) begin
      if (cont) begin gi = !ptr_m; gd = ptr_m; end
      else begin gi = ir; gd = dr | dw; end
    end
    acc = gi | gd;
    sa  = gd ? da : ia;
    inr = (32'(sa) < 32'(DEPTH));

    chk("i_waitrequest", 32'(i_waitrequest), 32'(!gi));
    chk("d_waitrequest", 32'(d_waitrequest), 32'(!gd));
    chk("ram_chipselect", 32'(ram_chipselect), 32'(acc & inr));
    chk("ram_write", 32'(ram_write), 32'(gd & dw & inr));
    if (acc) chk("ram_address", 32'(ram_address), 32'(sa));
    chk("oob_error", 32'(oob_error), 32'(exp_oob));
    chk("conflict_count", 32'(conflict_count), 32'(cnt_m));

    chk("i_readdatavalid", 32'(i_readdatavalid), 32'(pend_i & !rst));
    popped = 1'b0;
    if (i_readdatavalid && qi.size() > 0) begin
      e = qi.pop_front(); popped = 1'b1;
      chk("i_readdata", i_readdata, e);
    end else chk("i_readdata_idle", i_readdata, 32'h0);
    if (pend_i && !popped && qi.size() > 0) void'(qi.pop_front());

    chk("d_readdatavalid", 32'(d_readdatavalid), 32'(pend_d & !rst));
    popped = 1'b0;
    if (d_readdatavalid && qd.size() > 0) begin
      e = qd.pop_front(); popped = 1'b1;
      chk("d_readdata", d_readdata, e);
    end else chk("d_readdata_idle", d_readdata, 32'h0);
    if (pend_d && !popped && qd.size() > 0) void'(qd.pop_front());

    exp_oob = acc & !inr;
    pend_i  = gi;
    pend_d  = gd & !dw;
    if (gi) qi.push_back(inr ? shadow[ia] : 32'h0);
    if (gd && !dw) qd.push_back(inr ? shadow[da] : 32'h0);
    if (gd && dw && inr) shadow[da] = merge(shadow[da], wd, be);
    if (rst) begin
      ptr_m = 1'b0; cnt_m = 0;
    end else if (cont) begin
      ptr_m = !ptr_m;
      if (cnt_m < (1 << CNT_W) - 1) cnt_m++;
    end
  endtask

  task automatic idle(input bit rst);
    cycle(rst, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      shadow[a]  = 32'hA500_0000 ^ 32'(a);
      ram_mem[a] = 32'hA500_0000 ^ 32'(a);
    end
    shadow[0] = 32'h13;  ram_mem[0] = 32'h13;
    shadow[1] = 32'h93;  ram_mem[1] = 32'h93;
    shadow[2] = 32'h113; ram_mem[2] = 32'h113;
    shadow[10] = 32'h1122_3344; ram_mem[10] = 32'h1122_3344;
    ram_readdata = '0;
    ptr_m = 1'b0; cnt_m = 0; pend_i = 1'b0; pend_d = 1'b0; exp_oob = 1'b0;

    reset = 1'b1; i_read = 1'b0; i_address = '0; d_read = 1'b0; d_write = 1'b0;
    d_address = '0; d_byteenable = '0; d_writedata = '0;
    repeat (2) @(posedge clk);

    // reset state
    idle(1'b1);
    idle(1'b1);

    // back-to-back fetch reads
    cycle(1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 16'd0, 4'h0, 32'h0);
    cycle(1'b0, 1'b1, 16'd1, 1'b0, 1'b0, 16'd0, 4'h0, 32'h0);
    cycle(1'b0, 1'b1, 16'd2, 1'b0, 1'b0, 16'd0, 4'h0, 32'h0);
    idle(1'b0);
    idle(1'b0);

    // partial-byte write then read back
    cycle(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 16'd10, 4'b0011, 32'hDEAD_BEEF);
    cycle(1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd10, 4'h0, 32'h0);
    idle(1'b0);
    chk("merged_word", shadow[10], 32'h1122_BEEF);

    // four contended cycles straight after reset
    idle(1'b1);
    repeat (4) cycle(1'b0, 1'b1, 16'd5, 1'b1, 1'b0, 16'd6, 4'h0, 32'h0);
    idle(1'b0);
    chk("conflict_after_4", 32'(conflict_count), 32'd4);

    // out-of-range write, then read
    cycle(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 16'd40000, 4'hF, 32'hCAFE_F00D);
    cycle(1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd40000, 4'h0, 32'h0);
    idle(1'b0);
    idle(1'b0);

    // leave pointer on data, accept a read, reset mid-flight, fetch wins after
    cycle(1'b0, 1'b1, 16'd3, 1'b1, 1'b0, 16'd4, 4'h0, 32'h0);
    cycle(1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 16'd7, 4'h0, 32'h0);
    idle(1'b1);
    cycle(1'b0, 1'b1, 16'd8, 1'b1, 1'b0, 16'd9, 4'h0, 32'h0);
    idle(1'b0);

    // saturate the contention counter
    idle(1'b1);
    repeat (20) cycle(1'b0, 1'b1, 16'd11, 1'b0, 1'b1, 16'd12, 4'hF, 32'h5555_AAAA);
    idle(1'b0);
    chk("conflict_saturated", 32'(conflict_count), 32'd15);

    // random mix including out-of-range addresses and occasional reset
    for (int n = 0; n < 400; n++) begin
      logic [15:0] ra, rb;
      bit rr, rw;
      ra = ($urandom_range(0, 7) == 0) ? 16'(40000 + $urandom_range(0, 99)) : 16'($urandom_range(0, 63));
      rb = ($urandom_range(0, 7) == 0) ? 16'(40000 + $urandom_range(0, 99)) : 16'($urandom_range(0, 63));
      rr = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 2) == 0);
      cycle(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), ra, rr, rw, rb,
            4'($urandom_range(0, 15)), $urandom);
    end
    idle(1'b0);
    idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
